// File: rtl/conv_stream_ctrl.sv
// Stream sequencer for the 5x5 convolver: pixel handshake, weight-load pulse,
// full-window tracking and a 2-entry tagged result buffer.
// Optional build macro CONV_STREAM_CTRL_RELU_EN clamps stored results at zero.
module conv_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int CNT_W       = $clog2(IMAGE_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         reload_w,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] dp_pixel,
  output logic                         dp_shift,
  output logic                         dp_write,
  input  logic signed [DATA_WIDTH-1:0] dp_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]             out_row,
  output logic [CNT_W-1:0]             out_col,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] WIN_START = CNT_W'(KERNEL_SIZE - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            row_q, row_d, col_q, col_d;
  logic                        pend_q, pend_d;
  logic [CNT_W-1:0]            tag_row_q, tag_row_d, tag_col_q, tag_col_d;
  logic [1:0]                  count_q, count_d;
  logic                        wr_ptr_q, rd_ptr_q;
  logic signed [DATA_WIDTH-1:0] mem_data_q [0:1];
  logic [CNT_W-1:0]            mem_row_q [0:1];
  logic [CNT_W-1:0]            mem_col_q [0:1];

  logic       push, pop, accept, win_acc, last_acc;
  logic [2:0] occ;

  function automatic logic signed [DATA_WIDTH-1:0] store_val(
    input logic signed [DATA_WIDTH-1:0] v);
`ifdef CONV_STREAM_CTRL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Occupancy the buffer will have once the in-flight window lands; at most
  // one slot may be claimed, so a new window result always finds room.
  assign pop      = (count_q != 2'd0) && out_ready;
  assign push     = pend_q;
  assign occ      = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
  assign in_ready = (state_q == S_STREAM) && (occ <= 3'd1);
  assign accept   = in_valid && in_ready;
  assign win_acc  = accept && (row_q >= WIN_START) && (col_q >= WIN_START);
  assign last_acc = accept && (row_q == LAST_POS) && (col_q == LAST_POS);

  assign dp_shift  = accept;
  assign dp_pixel  = in_data;
  assign dp_write  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_data_q[rd_ptr_q];
  assign out_row   = mem_row_q[rd_ptr_q];
  assign out_col   = mem_col_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pend_d    = pend_q;
    tag_row_d = tag_row_q;
    tag_col_d = tag_col_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      S_IDLE:   if (start) state_d = reload_w ? S_LOAD : S_STREAM;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (last_acc) state_d = S_DRAIN;
      S_DRAIN:  if (!pend_q && (count_q == 2'd0)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (win_acc) begin
      pend_d    = 1'b1;
      tag_row_d = row_q - WIN_START;
      tag_col_d = col_q - WIN_START;
    end else if (pend_q) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      pend_q    <= 1'b0;
      tag_row_q <= '0;
      tag_col_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_row_q[i]  <= '0;
        mem_col_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pend_q    <= pend_d;
      tag_row_q <= tag_row_d;
      tag_col_q <= tag_col_d;
      count_q   <= count_d;
      // dp_result belongs to the window accepted on the previous edge
      if (push) begin
        mem_data_q[wr_ptr_q] <= store_val(dp_result);
        mem_row_q[wr_ptr_q]  <= tag_row_q;
        mem_col_q[wr_ptr_q]  <= tag_col_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: a behavioural 5x5 datapath stub plus a reference
// queue of expected (value,row,col) results computed straight from the image.
module tb_conv_stream_ctrl;

  logic               clk = 1'b0;
  logic               reset, start, reload_w, in_valid, out_ready;
  logic signed [15:0] in_data, dp_pixel, dp_result, out_data;
  logic               in_ready, dp_shift, dp_write, out_valid, busy, done;
  logic [4:0]         out_row, out_col;

  conv_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .reload_w(reload_w),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_pixel(dp_pixel), .dp_shift(dp_shift), .dp_write(dp_write),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; int r; int c; } exp_t;

  logic signed [15:0] img [784];
  logic signed [15:0] wts_tb [25];
  logic signed [15:0] w_act [25];
  logic signed [15:0] wcur [25];
  logic signed [15:0] hist [784];
  exp_t               q [$];
  int shift_idx = 0;
  int wr_cnt = 0;
  int checks = 0, errors = 0;
  int pidx, nres, done_cnt, first_ov, acc116, first_acc, last_acc, wr0, gcyc = 0;
  logic [15:0] first_data;

  // Datapath stub: result for the pixel shifted at an edge is valid only in
  // the following cycle; every other cycle carries noise.
  function automatic logic [15:0] stub_conv(input int k);
    int r = k / 28;
    int c = k % 28;
    int s = 0;
    int m;
    if (r < 4 || c < 4) return 16'($urandom);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        m = (r - 4 + i) * 28 + (c - 4 + j);
        s += int'(wcur[i*5+j]) * int'((m == k) ? dp_pixel : hist[m]);
      end
    s = s >>> 8;
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    if (!reset) shift_idx <= 0;
    else if (start && !busy) shift_idx <= 0;
    else if (dp_shift) shift_idx <= shift_idx + 1;
    if (dp_write) begin
      wr_cnt <= wr_cnt + 1;
      for (int i = 0; i < 25; i++) wcur[i] <= wts_tb[i];
    end
    if (dp_shift && shift_idx < 784) begin
      hist[shift_idx] <= dp_pixel;
      dp_result       <= stub_conv(shift_idx);
    end else begin
      dp_result <= 16'($urandom);
    end
  end

  function automatic logic [15:0] conv_at(input int orow, input int ocol);
    int s = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s += int'(w_act[i*5+j]) * int'(img[(orow+i)*28 + ocol + j]);
    s = s >>> 8;
`ifdef CONV_STREAM_CTRL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_queue();
    q.delete();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) q.push_back('{conv_at(r, c), r, c});
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < 784; i++) img[i] = 16'(int'($urandom_range(1023)) - 512);
  endtask

  task automatic new_weights(input logic signed [15:0] fixed, input bit rnd);
    for (int i = 0; i < 25; i++) begin
      wts_tb[i] = rnd ? 16'(int'($urandom_range(1023)) - 512) : fixed;
      w_act[i]  = wts_tb[i];
    end
  endtask

  task automatic begin_image(input bit rl);
    pidx = 0; nres = 0; done_cnt = 0; first_ov = -1; acc116 = -1;
    first_acc = -1; last_acc = -1; wr0 = wr_cnt;
    start = 1'b1; reload_w = rl; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); gcyc++;
    start = 1'b0; reload_w = 1'b0;
  endtask

  task automatic run(input int vpct, input int rpct, input int ncyc,
                     input bit must_finish, input bit busy_starts, input string tag);
    int  cyc = 0;
    bit  fin = 0;
    exp_t e;
    while (!fin) begin
      in_valid  = (pidx < 784) && ($urandom_range(99) < vpct);
      in_data   = (pidx < 784) ? img[pidx] : 16'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      start     = busy_starts && ($urandom_range(9) == 0);
      reload_w  = 1'($urandom_range(1));
      #1;
      chk({tag, " dp_shift"}, {31'b0, dp_shift}, {31'b0, in_valid && in_ready});
      if (out_valid && first_ov < 0) first_ov = gcyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk({tag, " extra_result"}, 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          if (nres == 0) first_data = out_data;
          chk({tag, " out_data"}, {16'h0, out_data}, {16'h0, e.d});
          chk({tag, " out_row"}, {27'b0, out_row}, e.r);
          chk({tag, " out_col"}, {27'b0, out_col}, e.c);
          nres++;
        end
      end
      if (in_valid && in_ready) begin
        if (pidx == 0) first_acc = gcyc;
        if (pidx == 116) acc116 = gcyc;
        last_acc = gcyc;
        pidx++;
      end
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      @(negedge clk); gcyc++; cyc++;
      if (!fin && cyc >= ncyc) begin
        if (must_finish) chk({tag, " timeout"}, 32'd0, 32'd1);
        fin = 1;
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input int rl);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " results"}, nres, 576);
    chk({tag, " leftover"}, q.size(), 0);
    chk({tag, " pixels"}, pidx, 784);
    chk({tag, " dp_write_cycles"}, wr_cnt - wr0, rl);
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " dp_write"}, {31'b0, dp_write}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; reload_w = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset out_data", {16'h0, out_data}, 32'd0);
    chk("reset out_row", {27'b0, out_row}, 32'd0);
    chk("reset out_col", {27'b0, out_col}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Image A: unit weights and pixels at full throughput
    new_weights(16'sh0100, 1'b0);
    for (int i = 0; i < 784; i++) img[i] = 16'sh0100;
    build_queue();
    begin_image(1'b1);
    run(100, 100, 2000, 1'b1, 1'b0, "A");
    finish_checks("A", 1);
    chk("A first_data", {16'h0, first_data}, 32'h1900);
    chk("A latency", first_ov - acc116, 2);
    chk("A consecutive", last_acc - first_acc, 783);

    // Image B: consumer stalled, then released
    new_weights('0, 1'b1);
    rand_pixels();
    build_queue();
    begin_image(1'b1);
    run(100, 0, 200, 1'b0, 1'b0, "B_stall");
    chk("B stall pixels", pidx, 118);
    chk("B stall in_ready", {31'b0, in_ready}, 32'd0);
    chk("B stall out_valid", {31'b0, out_valid}, 32'd1);
    chk("B stall head_row", {27'b0, out_row}, 32'd0);
    chk("B stall head_col", {27'b0, out_col}, 32'd0);
    chk("B stall head_data", {16'h0, out_data}, {16'h0, q[0].d});
    run(100, 100, 3000, 1'b1, 1'b0, "B");
    finish_checks("B", 1);

    // Image C: abandoned by reset mid-stream
    rand_pixels();
    build_queue();
    begin_image(1'b0);
    run(50, 50, 300, 1'b0, 1'b0, "C");
    chk("C busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("C reset1");
    @(negedge clk);
    chk_idle("C reset2");
    reset = 1'b1;
    @(negedge clk);
    chk_idle("C after");

    // Images D/E/F: random handshakes with stray start pulses while busy
    for (int k = 0; k < 3; k++) begin
      if (k != 0) new_weights('0, 1'b1);
      rand_pixels();
      build_queue();
      begin_image(k != 0);
      run(50, 50, 12000, 1'b1, 1'b1, $sformatf("R%0d", k));
      finish_checks($sformatf("R%0d", k), (k != 0) ? 1 : 0);
    end

    // Image G: negative sums
    new_weights(-16'sh0100, 1'b0);
    for (int i = 0; i < 784; i++) img[i] = 16'sh0100;
    build_queue();
    begin_image(1'b1);
    run(100, 100, 2000, 1'b1, 1'b0, "G");
    finish_checks("G", 1);
`ifdef CONV_STREAM_CTRL_RELU_EN
    chk("G first_data", {16'h0, first_data}, 32'h0000);
`else
    chk("G first_data", {16'h0, first_data}, 32'hE700);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
